// File: rtl/ipsxe_floating_point_fixed_accum_v1_0_pkg.sv
// rtl/ipsxe_floating_point_fixed_accum_v1_0_pkg.sv - shared widths, saturation limits and sign extension
package ipsxe_floating_point_fixed_accum_v1_0_pkg;

  // Widest accumulator any instance may use; helpers work at this width and callers cast down.
  localparam int MAX_W = 128;

  function automatic int acc_width(input int int_bit, input int frac_bit, input int guard_bit);
    return int_bit + frac_bit + guard_bit;
  endfunction

  // Lower w bits hold {0,1..1}.
  function automatic logic [MAX_W-1:0] acc_max(input int w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

  // Lower w bits hold {1,0..0}.
  function automatic logic [MAX_W-1:0] acc_min(input int w);
    return MAX_W'(1) << (w - 1);
  endfunction

  function automatic logic [MAX_W-1:0] sign_ext(input logic [MAX_W-1:0] x, input int w);
    logic [MAX_W-1:0] r;
    for (int i = 0; i < MAX_W; i++) begin
      r[i] = (i < w) ? x[i] : x[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_fixed_accum_v1_0_if.sv
// rtl/ipsxe_floating_point_fixed_accum_v1_0_if.sv - input beat, result stream and flag bundle
interface ipsxe_floating_point_fixed_accum_v1_0_if #(
  parameter int IN_BIT  = 32,
  parameter int ACC_BIT = 40
);
  logic               i_aclken;
  logic [IN_BIT-1:0]  i_axi4s_a_tdata;
  logic               i_axi4s_a_tvalid;
  logic               i_axi4s_a_tlast;
  logic               i_invalid_op;
  logic               i_overflow;
  logic               o_axi4s_a_tready;
  logic [ACC_BIT-1:0] o_axi4s_result_tdata;
  logic               o_axi4s_result_tvalid;
  logic               o_axi4s_result_tlast;
  logic               i_m_axis_result_tready;
  logic               o_invalid_op;
  logic               o_overflow;

  modport slave (
    input  i_aclken, i_axi4s_a_tdata, i_axi4s_a_tvalid, i_axi4s_a_tlast,
    input  i_invalid_op, i_overflow, i_m_axis_result_tready,
    output o_axi4s_a_tready, o_axi4s_result_tdata, o_axi4s_result_tvalid,
    output o_axi4s_result_tlast, o_invalid_op, o_overflow
  );

  modport master (
    output i_aclken, i_axi4s_a_tdata, i_axi4s_a_tvalid, i_axi4s_a_tlast,
    output i_invalid_op, i_overflow, i_m_axis_result_tready,
    input  o_axi4s_a_tready, o_axi4s_result_tdata, o_axi4s_result_tvalid,
    input  o_axi4s_result_tlast, o_invalid_op, o_overflow
  );
endinterface

// File: rtl/ipsxe_floating_point_sat_add_v1_0.sv
// rtl/ipsxe_floating_point_sat_add_v1_0.sv - combinational two's-complement adder clamping to W bits
module ipsxe_floating_point_sat_add_v1_0
  import ipsxe_floating_point_fixed_accum_v1_0_pkg::*;
#(
  parameter int W = 40
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         sat
);
  localparam logic [MAX_W-1:0] MAX_V = acc_max(W);
  localparam logic [MAX_W-1:0] MIN_V = acc_min(W);

  logic [W:0] full;

  assign full = {a[W-1], a} + {b[W-1], b};
  // The top two bits of the W+1 sum disagree exactly when the result left the W-bit range.
  assign sat  = full[W] ^ full[W-1];
  assign sum  = !sat ? full[W-1:0] : (full[W] ? W'(MIN_V) : W'(MAX_V));
endmodule

// File: rtl/ipsxe_floating_point_fixed_accum_v1_0.sv
// rtl/ipsxe_floating_point_fixed_accum_v1_0.sv - per-packet saturating fixed-point accumulator
module ipsxe_floating_point_fixed_accum_v1_0
  import ipsxe_floating_point_fixed_accum_v1_0_pkg::*;
#(
  parameter int FIXED_INT_BIT  = 32,
  parameter int FIXED_FRAC_BIT = 0,
  parameter int GUARD_BIT      = 8
) (
  input logic i_aclk,
  input logic i_areset,
  ipsxe_floating_point_fixed_accum_v1_0_if.slave bus
);
  localparam int IN_BIT  = FIXED_INT_BIT + FIXED_FRAC_BIT;
  localparam int ACC_BIT = acc_width(FIXED_INT_BIT, FIXED_FRAC_BIT, GUARD_BIT);

  logic               first_beat;
  logic               accept;
  logic               sat;
  logic [ACC_BIT-1:0] beat_ext;
  logic [ACC_BIT-1:0] addend;
  logic [ACC_BIT-1:0] sum;

  assign bus.o_axi4s_a_tready = !bus.o_axi4s_result_tvalid || bus.i_m_axis_result_tready;
  assign accept   = bus.i_axi4s_a_tvalid && bus.o_axi4s_a_tready && bus.i_aclken;
  assign beat_ext = ACC_BIT'(sign_ext(MAX_W'(bus.i_axi4s_a_tdata), IN_BIT));
  // The result register doubles as the accumulator; a new packet adds to zero instead.
  assign addend   = first_beat ? '0 : bus.o_axi4s_result_tdata;

  ipsxe_floating_point_sat_add_v1_0 #(.W(ACC_BIT)) u_sat_add (
    .a   (addend),
    .b   (beat_ext),
    .sum (sum),
    .sat (sat)
  );

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      bus.o_axi4s_result_tdata  <= '0;
      bus.o_axi4s_result_tvalid <= 1'b0;
      bus.o_axi4s_result_tlast  <= 1'b0;
      bus.o_invalid_op          <= 1'b0;
      bus.o_overflow            <= 1'b0;
      first_beat                <= 1'b1;
    end else if (bus.i_aclken) begin
      if (accept) begin
        bus.o_axi4s_result_tdata  <= sum;
        bus.o_axi4s_result_tvalid <= 1'b1;
        bus.o_axi4s_result_tlast  <= bus.i_axi4s_a_tlast;
        bus.o_invalid_op          <= bus.i_invalid_op | (!first_beat & bus.o_invalid_op);
        bus.o_overflow            <= bus.i_overflow | sat | (!first_beat & bus.o_overflow);
        first_beat                <= bus.i_axi4s_a_tlast;
      end else if (bus.i_m_axis_result_tready) begin
        bus.o_axi4s_result_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ipsxe_floating_point_fixed_accum_v1_0.sv
// tb/tb_ipsxe_floating_point_fixed_accum_v1_0.sv - randomized and directed checks against a packet-sum model
module tb_ipsxe_floating_point_fixed_accum_v1_0;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        inv = 1'b0;
  logic        ovf = 1'b0;
  logic        dready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance 0: 8 guard bits (40-bit sum); instance 1: no guard bits (32-bit sum).
  ipsxe_floating_point_fixed_accum_v1_0_if #(.IN_BIT(32), .ACC_BIT(40)) if0 ();
  ipsxe_floating_point_fixed_accum_v1_0_if #(.IN_BIT(32), .ACC_BIT(32)) if1 ();

  assign if0.i_aclken = en;             assign if1.i_aclken = en;
  assign if0.i_axi4s_a_tdata = tdata;   assign if1.i_axi4s_a_tdata = tdata;
  assign if0.i_axi4s_a_tvalid = tvalid; assign if1.i_axi4s_a_tvalid = tvalid;
  assign if0.i_axi4s_a_tlast = tlast;   assign if1.i_axi4s_a_tlast = tlast;
  assign if0.i_invalid_op = inv;        assign if1.i_invalid_op = inv;
  assign if0.i_overflow = ovf;          assign if1.i_overflow = ovf;
  assign if0.i_m_axis_result_tready = dready;
  assign if1.i_m_axis_result_tready = dready;

  ipsxe_floating_point_fixed_accum_v1_0 #(.FIXED_INT_BIT(32), .FIXED_FRAC_BIT(0), .GUARD_BIT(8))
    dut0 (.i_aclk(clk), .i_areset(rst), .bus(if0));
  ipsxe_floating_point_fixed_accum_v1_0 #(.FIXED_INT_BIT(32), .FIXED_FRAC_BIT(0), .GUARD_BIT(0))
    dut1 (.i_aclk(clk), .i_areset(rst), .bus(if1));

  always #5 clk = ~clk;

  // Model: expected result-port contents per instance, derived from packet sums.
  int     acc_bits [2] = '{40, 32};
  longint m_sum    [2];
  bit     m_valid  [2];
  bit     m_last   [2];
  bit     m_inv    [2];
  bit     m_ovf    [2];
  bit     m_new    [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_sum[k] = 0; m_valid[k] = 0; m_last[k] = 0;
      m_inv[k] = 0; m_ovf[k] = 0; m_new[k] = 1;
    end
  endtask

  task automatic model_step(input int k);
    longint hi, lo, s;
    bit     clip;
    hi = (longint'(1) <<< (acc_bits[k] - 1)) - 1;
    lo = -(longint'(1) <<< (acc_bits[k] - 1));
    if (!en) return;
    if (tvalid && (!m_valid[k] || dready)) begin
      s = (m_new[k] ? 0 : m_sum[k]) + longint'($signed(tdata));
      clip = 0;
      if (s > hi) begin s = hi; clip = 1; end
      else if (s < lo) begin s = lo; clip = 1; end
      m_sum[k]   = s;
      m_valid[k] = 1;
      m_last[k]  = tlast;
      m_inv[k]   = (m_new[k] ? 1'b0 : m_inv[k]) | inv;
      m_ovf[k]   = (m_new[k] ? 1'b0 : m_ovf[k]) | ovf | clip;
      m_new[k]   = tlast;
    end else if (dready) begin
      m_valid[k] = 0;
    end
  endtask

  initial model_reset();

  always @(posedge clk) if (!rst) for (int k = 0; k < 2; k++) model_step(k);

  task automatic chk(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cmp_inst(input int k, input bit rdy, input bit vld, input longint dat,
                          input bit lst, input bit iv, input bit ov);
    chk($sformatf("dut%0d tready", k), longint'(rdy), longint'(!m_valid[k] || dready));
    chk($sformatf("dut%0d tvalid", k), longint'(vld), longint'(m_valid[k]));
    if (m_valid[k]) begin
      chk($sformatf("dut%0d tdata", k), dat, m_sum[k]);
      chk($sformatf("dut%0d tlast", k), longint'(lst), longint'(m_last[k]));
      chk($sformatf("dut%0d invalid_op", k), longint'(iv), longint'(m_inv[k]));
      chk($sformatf("dut%0d overflow", k), longint'(ov), longint'(m_ovf[k]));
    end
  endtask

  always @(negedge clk) begin
    cmp_inst(0, if0.o_axi4s_a_tready, if0.o_axi4s_result_tvalid,
             longint'($signed(if0.o_axi4s_result_tdata)), if0.o_axi4s_result_tlast,
             if0.o_invalid_op, if0.o_overflow);
    cmp_inst(1, if1.o_axi4s_a_tready, if1.o_axi4s_result_tvalid,
             longint'($signed(if1.o_axi4s_result_tdata)), if1.o_axi4s_result_tlast,
             if1.o_invalid_op, if1.o_overflow);
  end

  // Drive one cycle of inputs just after a rising edge, then wait to the falling edge,
  // where the outputs show the beat presented on the previous call.
  task automatic beat(input bit v, input logic [31:0] d, input bit l, input bit iv = 0,
                      input bit ov = 0, input bit rdy = 1, input bit ce = 1);
    @(posedge clk); #1;
    tvalid = v; tdata = d; tlast = l; inv = iv; ovf = ov; dready = rdy; en = ce;
    @(negedge clk);
  endtask

  task automatic idle();
    beat(0, 32'h0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; tvalid = 0; model_reset();
    @(negedge clk);
    @(posedge clk); #1;
    rst = 0;
  endtask

  function automatic longint d0();
    return longint'($signed(if0.o_axi4s_result_tdata));
  endfunction

  function automatic longint d1();
    return longint'($signed(if1.o_axi4s_result_tdata));
  endfunction

  initial begin
    logic [31:0] rd;
    repeat (2) @(negedge clk);
    chk("reset tvalid", longint'(if0.o_axi4s_result_tvalid), 0);
    chk("reset tdata", d0(), 0);
    chk("reset flags", longint'({if0.o_axi4s_result_tlast, if0.o_invalid_op, if0.o_overflow}), 0);
    chk("reset tready", longint'(if0.o_axi4s_a_tready), 1);
    @(posedge clk); #1; rst = 0;

    // Reset in the middle of a packet; the next beat must start from zero.
    beat(1, 32'd100, 0); idle();
    chk("pre-reset sum", d0(), 100);
    do_reset();
    chk("mid reset tready", longint'(if0.o_axi4s_a_tready), 1);
    beat(1, 32'd9, 1); idle();
    chk("post-reset sum", d0(), 9);

    // 5, -3, 10 -> 5, 2, 12
    beat(1, 32'd5, 0); beat(1, -32'sd3, 0);
    chk("sum 5", d0(), 5); chk("last on 5", longint'(if0.o_axi4s_result_tlast), 0);
    beat(1, 32'd10, 1);
    chk("sum 2", d0(), 2); chk("last on 2", longint'(if0.o_axi4s_result_tlast), 0);
    idle();
    chk("sum 12", d0(), 12); chk("last on 12", longint'(if0.o_axi4s_result_tlast), 1);

    // Back-to-back single-beat packets
    beat(1, 32'd7, 1); beat(1, 32'd4, 1);
    chk("b2b first", d0(), 7);
    idle();
    chk("b2b second", d0(), 4);

    // Saturation without guard bits
    beat(1, 32'h7FFFFFFF, 0); beat(1, 32'h1, 1);
    chk("sat first ovf", longint'(if1.o_overflow), 0);
    beat(1, 32'd5, 1);
    chk("sat clamp", d1(), 64'sh7FFFFFFF);
    chk("sat ovf", longint'(if1.o_overflow), 1);
    chk("guard no clamp", d0(), 64'sh80000000);
    chk("guard no ovf", longint'(if0.o_overflow), 0);
    idle();
    chk("sat next pkt", d1(), 5);
    chk("sat next ovf", longint'(if1.o_overflow), 0);

    // Downstream stall for three cycles
    beat(1, 32'd7, 0);
    for (int i = 0; i < 3; i++) begin
      beat(1, 32'd3, 1, 0, 0, 0);
      chk("stall tready", longint'(if0.o_axi4s_a_tready), 0);
      chk("stall hold", d0(), 7);
    end
    beat(1, 32'd3, 1); idle();
    chk("after stall", d0(), 10);

    // invalid_op on beat 2 of 4
    beat(1, 32'd1, 0, 0); beat(1, 32'd2, 0, 1);
    chk("inv beat1", longint'(if0.o_invalid_op), 0);
    beat(1, 32'd3, 0, 0);
    chk("inv beat2", longint'(if0.o_invalid_op), 1);
    beat(1, 32'd4, 1, 0);
    chk("inv beat3", longint'(if0.o_invalid_op), 1);
    beat(1, 32'd5, 1, 0);
    chk("inv beat4", longint'(if0.o_invalid_op), 1);
    idle();
    chk("inv next pkt", longint'(if0.o_invalid_op), 0);

    // Randomized traffic, checked every cycle by the model comparison
    for (int c = 0; c < 2000; c++) begin
      if (c == 900) begin
        do_reset();
      end else begin
        case ($urandom_range(0, 3))
          0: rd = 32'h7FFFFFFF;
          1: rd = 32'h80000000;
          2: rd = $urandom;
          default: rd = 32'($urandom_range(0, 40)) - 32'd20;
        endcase
        beat($urandom_range(0, 3) != 0, rd, $urandom_range(0, 3) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0);
      end
    end
    idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
